// File: rtl/sfp_pkg.sv
// Shared types and helpers for the sequential normalisation row.
// Width helpers keep the top and the divider agreeing on QW/SW.
package sfp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSum,
        StDiv,
        StOut
    } state_e;

    localparam int unsigned AbsW = 64;

    function automatic int unsigned qw_f(input int unsigned bw, input int unsigned frac);
        return bw + frac;
    endfunction

    function automatic int unsigned sw_f(input int unsigned bw, input int unsigned col);
        return bw + $clog2(col);
    endfunction

    // Wide magnitude; callers sign-extend in and truncate out, so the most
    // negative value maps to its exact unsigned magnitude.
    function automatic logic [AbsW-1:0] abs_f(input logic signed [AbsW-1:0] x);
        return x[AbsW-1] ? -x : x;
    endfunction

endpackage

// File: rtl/sfp_norm_seq_if.sv
// Input-vector and result handshake bundle for sfp_norm_seq.
interface sfp_norm_seq_if #(
    parameter int unsigned COL     = 8,
    parameter int unsigned BW_PSUM = 20
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     sign_keep;
    logic [COL*BW_PSUM-1:0]   sfp_in;
    logic                     out_valid;
    logic                     out_ready;
    logic [COL*BW_PSUM-1:0]   sfp_out;
    logic                     div_zero;

    modport master (
        output in_valid, sign_keep, sfp_in, out_ready,
        input  in_ready, out_valid, sfp_out, div_zero
    );

    modport slave (
        input  in_valid, sign_keep, sfp_in, out_ready,
        output in_ready, out_valid, sfp_out, div_zero
    );
endinterface

// File: rtl/sfp_seq_div.sv
// Restoring divider, one quotient bit per cycle, QW cycles per division.
// The start cycle performs the first step, so done pulses on the QW-th cycle.
module sfp_seq_div #(
    parameter int unsigned QW = 28,
    parameter int unsigned SW = 23
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [QW-1:0] dividend,
    input  logic [SW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [QW-1:0] quotient
);
    localparam int unsigned CntW = $clog2(QW + 1);

    logic [SW-1:0]   rem_q, rem_d, rem_src, rem_step;
    logic [QW-1:0]   acc_q, acc_d, acc_src, acc_step;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic [SW:0]     trial, diff;
    logic            ge;

    always_comb begin
        rem_src  = busy_q ? rem_q : '0;
        acc_src  = busy_q ? acc_q : dividend;
        trial    = {rem_src, acc_src[QW-1]};
        ge       = trial >= {1'b0, divisor};
        diff     = trial - {1'b0, divisor};
        rem_step = ge ? SW'(diff) : SW'(trial);
        acc_step = {acc_src[QW-2:0], ge};

        rem_d  = rem_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done   = 1'b0;
        if (busy_q) begin
            rem_d = rem_step;
            acc_d = acc_step;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntW'(QW - 1)) begin
                busy_d = 1'b0;
                done   = 1'b1;
            end
        end else if (start) begin
            rem_d  = rem_step;
            acc_d  = acc_step;
            cnt_d  = CntW'(1);
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q  <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign quotient = acc_step;

endmodule

// File: rtl/sfp_norm_seq.sv
// Normalises |x_c| * 2^FRAC by the vector's sum of magnitudes, one column at a
// time through a shared iterative divider.
module sfp_norm_seq
    import sfp_pkg::*;
#(
    parameter int unsigned COL     = 8,
    parameter int unsigned BW_PSUM = 20,
    parameter int unsigned FRAC    = 8
) (
    input  logic          clk,
    input  logic          reset,
    sfp_norm_seq_if.slave bus
);
    localparam int unsigned QW = qw_f(BW_PSUM, FRAC);
    localparam int unsigned SW = sw_f(BW_PSUM, COL);
    localparam int unsigned CW = (COL > 1) ? $clog2(COL) : 1;

    logic signed [BW_PSUM-1:0] x_in   [COL];
    logic        [BW_PSUM-1:0] abs_in [COL];

    state_e               state_q, state_d;
    logic [BW_PSUM-1:0]   abs_q [COL];
    logic [BW_PSUM-1:0]   abs_d [COL];
    logic [BW_PSUM-1:0]   out_q [COL];
    logic [BW_PSUM-1:0]   out_d [COL];
    logic [COL-1:0]       sign_q, sign_d;
    logic                 keep_q, keep_d;
    logic [SW-1:0]        sum_q, sum_d, sum_w;
    logic [CW-1:0]        col_q, col_d;
    logic                 zero_q, zero_d;

    logic                 div_start, div_busy, div_done;
    logic [QW-1:0]        div_dvd, div_quo;
    logic [BW_PSUM-1:0]   q_res;

    always_comb begin
        for (int c = 0; c < COL; c++) begin
            x_in[c]   = bus.sfp_in[c*BW_PSUM +: BW_PSUM];
            abs_in[c] = BW_PSUM'(abs_f(AbsW'(x_in[c])));
        end
    end

    always_comb begin
        sum_w = '0;
        for (int c = 0; c < COL; c++) sum_w = sum_w + SW'(abs_q[c]);
    end

    assign div_dvd = QW'(abs_q[col_q]) << FRAC;
    // Quotient never exceeds 2^FRAC, so the low BW_PSUM bits hold it exactly.
    assign q_res   = BW_PSUM'(div_quo);

    sfp_seq_div #(
        .QW (QW),
        .SW (SW)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (div_dvd),
        .divisor  (sum_q),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    always_comb begin
        state_d   = state_q;
        abs_d     = abs_q;
        out_d     = out_q;
        sign_d    = sign_q;
        keep_d    = keep_q;
        sum_d     = sum_q;
        col_d     = col_q;
        zero_d    = zero_q;
        div_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    for (int c = 0; c < COL; c++) begin
                        abs_d[c]  = abs_in[c];
                        sign_d[c] = x_in[c][BW_PSUM-1];
                    end
                    keep_d  = bus.sign_keep;
                    state_d = StSum;
                end
            end
            StSum: begin
                sum_d = sum_w;
                if (sum_w == '0) begin
                    for (int c = 0; c < COL; c++) out_d[c] = '0;
                    zero_d  = 1'b1;
                    state_d = StOut;
                end else begin
                    col_d   = '0;
                    state_d = StDiv;
                end
            end
            StDiv: begin
                div_start = !div_busy;
                if (div_done) begin
                    out_d[col_q] = (keep_q && sign_q[col_q]) ? -q_res : q_res;
                    if (col_q == CW'(COL - 1)) state_d = StOut;
                    else                       col_d   = col_q + CW'(1);
                end
            end
            StOut: begin
                if (bus.out_ready) begin
                    zero_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            for (int c = 0; c < COL; c++) begin
                abs_q[c] <= '0;
                out_q[c] <= '0;
            end
            sign_q <= '0;
            keep_q <= 1'b0;
            sum_q  <= '0;
            col_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            abs_q   <= abs_d;
            out_q   <= out_d;
            sign_q  <= sign_d;
            keep_q  <= keep_d;
            sum_q   <= sum_d;
            col_q   <= col_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StOut);
    assign bus.div_zero  = zero_q;

    for (genvar g = 0; g < COL; g++) begin : g_pack
        assign bus.sfp_out[g*BW_PSUM +: BW_PSUM] = out_q[g];
    end

endmodule

// File: tb/tb_sfp_norm_seq.sv
// Self-checking bench for sfp_norm_seq: vector table plus scoreboard queue,
// with hand-written backpressure and mid-division reset sequences.
module tb_sfp_norm_seq;
    localparam int COL  = 8;
    localparam int BW   = 20;
    localparam int FRAC = 8;
    localparam int QW   = BW + FRAC;
    localparam int LAT  = 2 + COL * QW;
    localparam int TMO  = 3000;

    typedef logic [COL*BW-1:0] vec_t;
    typedef struct packed {
        vec_t vin;
        logic keep;
        vec_t exp;
        logic zero;
    } vrec_t;
    typedef struct packed {
        vec_t v;
        logic z;
        int   lat;
    } sb_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    sb_t  sb[$];
    vrec_t tbl[9];

    always #5 clk = ~clk;

    sfp_norm_seq_if #(.COL(COL), .BW_PSUM(BW)) bus ();

    sfp_norm_seq #(
        .COL     (COL),
        .BW_PSUM (BW),
        .FRAC    (FRAC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string name, input vec_t act, input vec_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic vec_t pk(input int a0, input int a1, input int a2, input int a3,
                                input int a4, input int a5, input int a6, input int a7);
        vec_t v;
        int   a[COL];
        a = '{a0, a1, a2, a3, a4, a5, a6, a7};
        v = '0;
        for (int c = 0; c < COL; c++) v[c*BW +: BW] = BW'(a[c]);
        return v;
    endfunction

    function automatic vec_t model(input vec_t v, input logic k, output logic z);
        longint s;
        longint q;
        longint a[COL];
        logic   neg[COL];
        logic signed [BW-1:0] x;
        vec_t   r;
        s = 0;
        r = '0;
        for (int c = 0; c < COL; c++) begin
            x      = signed'(v[c*BW +: BW]);
            neg[c] = (x < 0);
            a[c]   = (x < 0) ? -longint'(x) : longint'(x);
            s      = s + a[c];
        end
        z = (s == 0);
        if (s != 0) begin
            for (int c = 0; c < COL; c++) begin
                q = (a[c] << FRAC) / s;
                if (k && neg[c]) q = -q;
                r[c*BW +: BW] = BW'(q);
            end
        end
        return r;
    endfunction

    task automatic send(input vec_t v, input logic k, input vec_t e, input logic z);
        int   n;
        sb_t  s;
        n = 0;
        bus.sfp_in    = v;
        bus.sign_keep = k;
        bus.in_valid  = 1'b1;
        while (!bus.in_ready && n < TMO) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL in_ready_timeout: got busy after %0d cycles, want ready", n);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        s.v   = e;
        s.z   = z;
        s.lat = z ? 2 : LAT;
        sb.push_back(s);
    endtask

    task automatic collect(input string tag);
        int  n;
        sb_t s;
        n = 0;
        while (!bus.out_valid && n < TMO) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.out_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_out_valid_timeout: got no out_valid, want within %0d", tag, TMO);
        end
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_scoreboard: got result, want none pending", tag);
        end else begin
            s = sb.pop_front();
            chk({tag, "_latency"}, vec_t'(n + 1), vec_t'(s.lat));
            chk({tag, "_sfp_out"}, bus.sfp_out, s.v);
            chk({tag, "_div_zero"}, vec_t'(bus.div_zero), vec_t'(s.z));
        end
        if (bus.out_ready) begin
            @(posedge clk); #1;
            chk({tag, "_drained"}, vec_t'(bus.out_valid), vec_t'(0));
        end
    endtask

    initial begin
        vec_t v3;
        vec_t e3;
        vec_t v1;
        vec_t e1;
        logic z;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.sign_keep = 1'b0;
        bus.sfp_in    = '0;
        bus.out_ready = 1'b1;

        tbl[0] = '{pk(1, 1, 1, 1, 1, 1, 1, 1), 1'b0,
                   pk(32, 32, 32, 32, 32, 32, 32, 32), 1'b0};
        tbl[1] = '{pk(-4, 4, 0, 0, 0, 0, 0, 8), 1'b1,
                   pk(-64, 64, 0, 0, 0, 0, 0, 128), 1'b0};
        tbl[2] = '{pk(-4, 4, 0, 0, 0, 0, 0, 8), 1'b0,
                   pk(64, 64, 0, 0, 0, 0, 0, 128), 1'b0};
        tbl[3] = '{pk(0, 0, 0, 0, 0, 0, 0, 0), 1'b1, pk(0, 0, 0, 0, 0, 0, 0, 0), 1'b1};
        tbl[4] = '{pk(-524288, 0, 0, 0, 0, 0, 0, 0), 1'b1,
                   pk(-256, 0, 0, 0, 0, 0, 0, 0), 1'b0};
        tbl[5] = '{pk(-524288, 0, 0, 0, 0, 0, 0, 0), 1'b0,
                   pk(256, 0, 0, 0, 0, 0, 0, 0), 1'b0};
        for (int i = 6; i < 9; i++) begin
            tbl[i].vin = '0;
            for (int c = 0; c < COL; c++)
                tbl[i].vin[c*BW +: BW] = BW'(int'($urandom_range(0, 1048575)) - 524288);
            tbl[i].keep = (i != 7);
            tbl[i].exp  = model(tbl[i].vin, tbl[i].keep, z);
            tbl[i].zero = z;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", vec_t'(bus.in_ready), vec_t'(1));
        chk("rst_out_valid", vec_t'(bus.out_valid), vec_t'(0));
        chk("rst_div_zero", vec_t'(bus.div_zero), vec_t'(0));
        chk("rst_sfp_out", bus.sfp_out, '0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            send(tbl[i].vin, tbl[i].keep, tbl[i].exp, tbl[i].zero);
            collect($sformatf("vec%0d", i));
        end

        // Abort in the middle of column 3.
        send(tbl[0].vin, 1'b0, tbl[0].exp, 1'b0);
        repeat (1 + 3 * QW + 5) @(posedge clk);
        #1;
        chk("middiv_busy", vec_t'(bus.in_ready), vec_t'(0));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        void'(sb.pop_back());
        chk("abort_in_ready", vec_t'(bus.in_ready), vec_t'(1));
        chk("abort_out_valid", vec_t'(bus.out_valid), vec_t'(0));
        chk("abort_sfp_out", bus.sfp_out, '0);
        chk("abort_div_zero", vec_t'(bus.div_zero), vec_t'(0));

        // Backpressure: result held, next vector waits, then goes in right after drain.
        v3 = pk(3, 3, 3, 0, 0, 0, 0, 0);
        e3 = pk(85, 85, 85, 0, 0, 0, 0, 0);
        v1 = tbl[1].vin;
        e1 = tbl[1].exp;
        bus.out_ready = 1'b0;
        send(v3, 1'b0, e3, 1'b0);
        collect("bp");
        bus.sfp_in    = v1;
        bus.sign_keep = 1'b1;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_hold_sfp_out%0d", k), bus.sfp_out, e3);
            chk($sformatf("bp_hold_out_valid%0d", k), vec_t'(bus.out_valid), vec_t'(1));
            chk($sformatf("bp_hold_in_ready%0d", k), vec_t'(bus.in_ready), vec_t'(0));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_drain_out_valid", vec_t'(bus.out_valid), vec_t'(0));
        chk("bp_drain_in_ready", vec_t'(bus.in_ready), vec_t'(1));
        chk("bp_drain_sfp_out_kept", bus.sfp_out, e3);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("bp_next_accepted", vec_t'(bus.in_ready), vec_t'(0));
        sb.push_back('{v: e1, z: 1'b0, lat: LAT});
        collect("bp_next");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
